line_pixel_writer: RTL

- Downstream consumer of the bresenham line stepper. Takes each plotted (x, y) point and commits it to the greyscale framebuffer memory.
- Per pixel: clips the point, computes the linear address, then does a read-modify-write that darkens the pixel by DARKEN, saturating at 0. This gives cumulative string-art shading.
- Back-pressures the stepper through its enable input.

---
 rtl/line_draw_pkg.sv | 12 +
 rtl/pix_addr_calc.sv | 22 ++
 rtl/line_pixel_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/line_draw_pkg.sv
// Shared types and framebuffer geometry for the line-drawing pixel path.
package line_draw_pkg;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_ADDR_W = 19;
  localparam int PIX_W     = 8;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic signed [31:0] coord_t;

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} wr_state_t;
endpackage

// File: rtl/pix_addr_calc.sv
// Combinational clip test and linear framebuffer address (y*WIDTH + x).
module pix_addr_calc
  import line_draw_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  coord_t            x,
  input  coord_t            y,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] addr
);

  // Signed bounds check; the address is only meaningful when in_bounds is set,
  // so truncation to ADDR_W cannot lose information for a legal point.
  always_comb begin
    in_bounds = (x >= 0) && (x < WIDTH) && (y >= 0) && (y < HEIGHT);
    addr      = ADDR_W'(y * WIDTH + x);
  end

endmodule

// File: rtl/line_pixel_writer.sv
// Commits stepper points to the greyscale framebuffer, one pixel in flight.
// Build option LINE_WRITER_RMW_EN: read-modify-write darkening by DARKEN;
// without it each in-bounds point is a single blind write of INK.
module line_pixel_writer
  import line_draw_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int PIX_W  = 8,
  parameter int DARKEN = 32,
  parameter int INK    = 0,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_plot,
  input  logic [31:0]       in_x,
  input  logic [31:0]       in_y,
  input  logic              in_done,
  output logic              in_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              mem_write,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              out_done,
  output logic [31:0]       pix_count,
  output logic [15:0]       clip_count
);

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              out_done_q, out_done_d;
  logic              armed_q, armed_d;
  logic [31:0]       pix_count_q, pix_count_d;
  logic [15:0]       clip_count_q, clip_count_d;
  logic              in_bounds;
  logic [ADDR_W-1:0] calc_addr;
  logic              accept, fire;

`ifdef LINE_WRITER_RMW_EN
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             unused_cfg;
  assign unused_cfg = ^PIX_W'(INK);
`else
  logic             unused_cfg;
  assign unused_cfg = ^{mem_rdata, PIX_W'(DARKEN), 32'(RD_LAT)};
`endif

  pix_addr_calc #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_calc (
    .x        (coord_t'(in_x)),
    .y        (coord_t'(in_y)),
    .in_bounds(in_bounds),
    .addr     (calc_addr)
  );

  assign in_enable = (state_q == IDLE) & ~reset;
  assign accept    = in_plot & in_enable;
  // out_done only after the pipe has drained and the stepper has nothing pending
  assign fire      = in_done & (state_q == IDLE) & ~in_plot & armed_q;

  // Next-state, memory strobes and counters
  always_comb begin
    state_d      = state_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pix_count_d  = pix_count_q;
    clip_count_d = clip_count_q;
    out_done_d   = fire;
    armed_d      = ~in_done | (armed_q & ~fire);
`ifdef LINE_WRITER_RMW_EN
    lat_d        = lat_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        if (in_bounds) begin
          mem_addr_d = calc_addr;
`ifdef LINE_WRITER_RMW_EN
          state_d    = READ;
          mem_read_d = 1'b1;
`else
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = PIX_W'(INK);
`endif
        end else if (clip_count_q != 16'hFFFF) begin
          clip_count_d = clip_count_q + 16'd1;
        end
      end
`ifdef LINE_WRITER_RMW_EN
      READ: begin
        state_d = WAIT;
        lat_d   = '0;
      end
      WAIT: begin
        if (lat_q == CNT_W'(RD_LAT - 1)) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = (mem_rdata > PIX_W'(DARKEN)) ? mem_rdata - PIX_W'(DARKEN) : '0;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
`endif
      WRITE: begin
        state_d     = IDLE;
        pix_count_d = pix_count_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any pixel in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      out_done_q   <= 1'b0;
      armed_q      <= 1'b1;
      pix_count_q  <= '0;
      clip_count_q <= '0;
`ifdef LINE_WRITER_RMW_EN
      lat_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      out_done_q   <= out_done_d;
      armed_q      <= armed_d;
      pix_count_q  <= pix_count_d;
      clip_count_q <= clip_count_d;
`ifdef LINE_WRITER_RMW_EN
      lat_q        <= lat_d;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;
  assign out_done   = out_done_q;
  assign pix_count  = pix_count_q;
  assign clip_count = clip_count_q;

endmodule
